// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: req/ack data-memory bus between the access controller and memory.
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences EX/MEM data-memory accesses over a variable-latency req/ack bus,
// stalling the pipeline until completion and flagging misaligned or timed-out accesses.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_write_i,
    input  logic                      mem_read_i,
    input  logic [31:0]               alu_rst_i,
    input  logic [31:0]               rdata2_i,
    input  logic                      err_clr_i,
    mem_access_ctrl_if.master         mem,
    output logic                      stall_o,
    output logic [31:0]               load_data_o,
    output logic                      load_valid_o,
    output logic                      bus_err_o,
    output logic [31:0]               err_addr_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d, rd_q, rd_d, err_q, err_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d, eaddr_q, eaddr_d;
    logic              mem_op;

    assign mem_op = mem_read_i | mem_write_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            eaddr_q <= eaddr_d;
        end
    end

    // A new error outranks a same-cycle err_clr, so the capture test looks past the clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        rd_d    = rd_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        eaddr_d = eaddr_q;
        if (err_clr_i) begin
            err_d   = 1'b0;
            eaddr_d = '0;
        end
        case (state_q)
            IDLE: if (mem_op) begin
                rd_d = ~mem_write_i;
                if (alu_rst_i[1:0] == 2'b00) begin
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = mem_write_i;
                    addr_d  = alu_rst_i;
                    wdata_d = rdata2_i;
                    cnt_d   = '0;
                end else begin
                    state_d = ERR;
                    ld_d    = '0;
                    if (!err_q || err_clr_i) begin
                        err_d   = 1'b1;
                        eaddr_d = alu_rst_i;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (mem.ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    ld_d    = we_q ? ld_q : mem.rdata;
                end else if (cnt_q == TMO) begin
                    state_d = ERR;
                    req_d   = 1'b0;
                    ld_d    = '0;
                    if (!err_q || err_clr_i) begin
                        err_d   = 1'b1;
                        eaddr_d = addr_q;
                    end
                end
            end
            DONE, ERR: state_d = IDLE;
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign mem.req      = req_q;
    assign mem.we       = we_q;
    assign mem.addr     = addr_q;
    assign mem.wdata    = wdata_q;
    assign stall_o      = rst_n & ((state_q == ACCESS) | ((state_q == IDLE) & mem_op));
    assign load_valid_o = rd_q & ((state_q == DONE) | (state_q == ERR));
    assign load_data_o  = ld_q;
    assign bus_err_o    = err_q;
    assign err_addr_o   = eaddr_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: per-cycle vector table for the basic flows plus hand-written
// sequences for timeout, ack-on-timeout and asynchronous reset mid-access.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write = 1'b0, mem_read = 1'b0, err_clr = 1'b0;
    logic [31:0] alu_rst = '0, rdata2 = '0;
    logic        stall, load_valid, bus_err;
    logic [31:0] load_data, err_addr;
    int          checks = 0, errors = 0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_write_i  (mem_write),
        .mem_read_i   (mem_read),
        .alu_rst_i    (alu_rst),
        .rdata2_i     (rdata2),
        .err_clr_i    (err_clr),
        .mem          (bus.master),
        .stall_o      (stall),
        .load_data_o  (load_data),
        .load_valid_o (load_valid),
        .bus_err_o    (bus_err),
        .err_addr_o   (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, ack, clr;
        logic [31:0] addr, wd, rdata;
        logic        req, we, stall, lv, err;
        logic [31:0] ld, ea, maddr, mwd;
    } vec_t;

    localparam logic [31:0] D = 32'hDEADBEEF;
    localparam logic [31:0] S = 32'h12345678;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic ack, input logic [31:0] rdata, input logic clr);
        mem_read  = rd;
        mem_write = wr;
        alu_rst   = addr;
        bus.ack   = ack;
        bus.rdata = rdata;
        err_clr   = clr;
    endtask

    // Runs one access that never gets acked and returns how many cycles mem_req stayed high.
    task automatic timeout_run(input logic [31:0] addr, output int n);
        n = 0;
        drive(1, 0, addr, 0, 0, 0);
        step();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.req) break;
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        bus.ack   = 1'b0;
        bus.rdata = '0;
        //        rd wr ak cl addr   wd  rdata  req we st lv er ld ea     maddr  mwd
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,0,0,0,0, 0, 0,     32'h00, 0});
        tv.push_back('{1,0,0,0, 32'h10, 0, 0,    0,0,1,0,0, 0, 0,     32'h00, 0});
        tv.push_back('{1,0,0,0, 32'h10, 0, 0,    1,0,1,0,0, 0, 0,     32'h10, 0});
        tv.push_back('{1,0,1,0, 32'h10, 0, D,    1,0,1,0,0, 0, 0,     32'h10, 0});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,0,0,1,0, D, 0,     32'h10, 0});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,0,0,0,0, D, 0,     32'h10, 0});
        tv.push_back('{0,1,0,0, 32'h20, S, 0,    0,0,1,0,0, D, 0,     32'h10, 0});
        tv.push_back('{0,1,1,0, 32'h20, S, 0,    1,1,1,0,0, D, 0,     32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,0,0, D, 0,     32'h20, S});
        tv.push_back('{1,0,0,0, 32'h13, 0, 0,    0,1,1,0,0, D, 0,     32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,1,1, 0, 32'h13, 32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,0,1, 0, 32'h13, 32'h20, S});
        tv.push_back('{0,1,0,0, 32'h22, 0, 0,    0,1,1,0,1, 0, 32'h13, 32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,0,1, 0, 32'h13, 32'h20, S});
        tv.push_back('{0,0,0,1, 32'h00, 0, 0,    0,1,0,0,1, 0, 32'h13, 32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,0,0, 0, 0,     32'h20, S});
        tv.push_back('{1,0,0,0, 32'h41, 0, 0,    0,1,1,0,0, 0, 0,     32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,1,1, 0, 32'h41, 32'h20, S});
        tv.push_back('{1,0,0,1, 32'h55, 0, 0,    0,1,1,0,1, 0, 32'h41, 32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,1,1, 0, 32'h55, 32'h20, S});
        tv.push_back('{0,0,0,1, 32'h00, 0, 0,    0,1,0,0,1, 0, 32'h55, 32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,0,0, 0, 0,     32'h20, S});
        tv.push_back('{0,0,1,0, 32'h00, 0, 32'hFFFFFFFF, 0,1,0,0,0, 0, 0, 32'h20, S});
        tv.push_back('{0,0,0,0, 32'h00, 0, 0,    0,1,0,0,0, 0, 0,     32'h20, S});

        #3;
        chk("reset req", {31'b0, bus.req}, 0);
        chk("reset stall", {31'b0, stall}, 0);
        chk("reset load_valid", {31'b0, load_valid}, 0);
        chk("reset bus_err", {31'b0, bus_err}, 0);
        chk("reset err_addr", err_addr, 0);
        chk("reset load_data", load_data, 0);
        #9 rst_n = 1'b1;
        step();

        foreach (tv[i]) begin
            drive(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].ack, tv[i].rdata, tv[i].clr);
            rdata2 = tv[i].wd;
            @(negedge clk);
            chk($sformatf("v%0d req", i), {31'b0, bus.req}, {31'b0, tv[i].req});
            chk($sformatf("v%0d we", i), {31'b0, bus.we}, {31'b0, tv[i].we});
            chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, tv[i].stall});
            chk($sformatf("v%0d load_valid", i), {31'b0, load_valid}, {31'b0, tv[i].lv});
            chk($sformatf("v%0d bus_err", i), {31'b0, bus_err}, {31'b0, tv[i].err});
            chk($sformatf("v%0d load_data", i), load_data, tv[i].ld);
            chk($sformatf("v%0d err_addr", i), err_addr, tv[i].ea);
            chk($sformatf("v%0d mem_addr", i), bus.addr, tv[i].maddr);
            chk($sformatf("v%0d mem_wdata", i), bus.wdata, tv[i].mwd);
            step();
        end

        timeout_run(32'h100, n);
        chk("timeout1 req cycles", n, 15);
        chk("timeout1 stall", {31'b0, stall}, 0);
        chk("timeout1 load_valid", {31'b0, load_valid}, 1);
        chk("timeout1 load_data", load_data, 0);
        chk("timeout1 bus_err", {31'b0, bus_err}, 1);
        chk("timeout1 err_addr", err_addr, 32'h100);
        drive(0, 0, 0, 1, 32'hFFFFFFFF, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stray ack req", {31'b0, bus.req}, 0);
        chk("stray ack load_valid", {31'b0, load_valid}, 0);
        chk("stray ack load_data", load_data, 0);
        step();

        timeout_run(32'h200, n);
        chk("timeout2 req cycles", n, 15);
        chk("timeout2 err_addr kept", err_addr, 32'h100);
        drive(0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("err_clr bus_err", {31'b0, bus_err}, 0);
        chk("err_clr err_addr", err_addr, 0);
        step();

        drive(1, 0, 32'h300, 0, 0, 0);
        step();
        for (int i = 0; i < 14; i++) step();
        drive(1, 0, 32'h300, 1, 32'hCAFEF00D, 0);
        @(negedge clk);
        chk("ack@timeout req", {31'b0, bus.req}, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ack@timeout load_valid", {31'b0, load_valid}, 1);
        chk("ack@timeout load_data", load_data, 32'hCAFEF00D);
        chk("ack@timeout bus_err", {31'b0, bus_err}, 0);
        chk("ack@timeout req drop", {31'b0, bus.req}, 0);
        step();

        drive(1, 0, 32'h400, 0, 0, 0);
        step();
        step();
        @(negedge clk);
        chk("pre-reset req", {31'b0, bus.req}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset req", {31'b0, bus.req}, 0);
        chk("async reset stall", {31'b0, stall}, 0);
        chk("async reset load_data", load_data, 0);
        chk("async reset mem_addr", bus.addr, 0);
        chk("async reset load_valid", {31'b0, load_valid}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 0, 32'h400, 1, 32'h11111111, 0);
        @(negedge clk);
        chk("post-reset late ack req", {31'b0, bus.req}, 0);
        chk("post-reset stall", {31'b0, stall}, 1);
        step();
        drive(1, 0, 32'h400, 1, 32'h0BADCAFE, 0);
        @(negedge clk);
        chk("post-reset access req", {31'b0, bus.req}, 1);
        chk("post-reset mem_addr", bus.addr, 32'h400);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post-reset load_valid", {31'b0, load_valid}, 1);
        chk("post-reset load_data", load_data, 32'h0BADCAFE);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
